// File: rtl/frontend_inst_queue_if.sv
// Handshake bundle between the fetch stage, the instruction queue and decode.
// The queue uses the slave modport; the fetch/decode side (or a bench) uses master.
interface frontend_inst_queue_if #(
   parameter int DATA_WIDTH = 80,
   parameter int DEPTH      = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                    flush_i;
   logic                    write_valid_i;
   logic                    write_ready_o;
   logic [1:0]              write_num_i;
   logic [2*DATA_WIDTH-1:0] write_data_i;
   logic [1:0]              read_valid_o;
   logic                    read_ready_i;
   logic [1:0]              read_num_i;
   logic [2*DATA_WIDTH-1:0] read_data_o;
   logic [CW-1:0]           count_o;

   modport master (
      output flush_i, write_valid_i, write_num_i, write_data_i, read_ready_i, read_num_i,
      input  write_ready_o, read_valid_o, read_data_o, count_o
   );

   modport slave (
      input  flush_i, write_valid_i, write_num_i, write_data_i, read_ready_i, read_num_i,
      output write_ready_o, read_valid_o, read_data_o, count_o
   );
endinterface

// File: rtl/frontend_inst_queue.sv
// Banked 2-write/2-read instruction queue between icache fetch and decode.
// Define FRONTEND_INST_QUEUE_BYPASS_EN to forward writes straight to the read side when empty.
module frontend_inst_queue #(
   parameter int DATA_WIDTH = 80,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   frontend_inst_queue_if.slave  bus
);
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int ROWS = DEPTH / 2;

   typedef logic [DATA_WIDTH-1:0] entry_t;

   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   entry_t        r_bank0 [ROWS];
   entry_t        r_bank1 [ROWS];

   entry_t        w_wslot0, w_wslot1, w_st0, w_st1, w_rd0, w_rd1;
   logic          w_wr_acc;
   logic [1:0]    w_wnum, w_rreq, w_avail, w_pop, w_store, w_rvalid;
   logic [PW-2:0] w_wrow, w_wrow_n, w_rrow, w_rrow_n;

   assign w_wslot0 = bus.write_data_i[DATA_WIDTH-1:0];
   assign w_wslot1 = bus.write_data_i[2*DATA_WIDTH-1:DATA_WIDTH];

   // Even/odd entries live in different banks, so a pair never collides on one bank.
   assign w_wrow   = r_wptr[PW-1:1];
   assign w_wrow_n = w_wrow + 1'b1;
   assign w_rrow   = r_rptr[PW-1:1];
   assign w_rrow_n = w_rrow + 1'b1;

   assign bus.write_ready_o = (r_count <= CW'(DEPTH - 2));
   assign w_wr_acc = bus.write_valid_i && bus.write_ready_o && !bus.flush_i;
   assign w_wnum   = w_wr_acc ? (bus.write_num_i[1] ? 2'd2 : bus.write_num_i) : 2'd0;
   assign w_rreq   = bus.read_ready_i ? (bus.read_num_i[1] ? 2'd2 : bus.read_num_i) : 2'd0;
   assign w_avail  = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_rd0    = r_rptr[0] ? r_bank1[w_rrow] : r_bank0[w_rrow];
      w_rd1    = r_rptr[0] ? r_bank0[w_rrow_n] : r_bank1[w_rrow];
      w_rvalid = {r_count >= CW'(2), r_count != '0};
      w_pop    = (w_rreq < w_avail) ? w_rreq : w_avail;
      w_store  = w_wnum;
      w_st0    = w_wslot0;
      w_st1    = w_wslot1;
`ifdef FRONTEND_INST_QUEUE_BYPASS_EN
      if (r_count == '0) begin
         // Entries consumed in the same cycle are never stored; only the remainder is written.
         w_rd0    = w_wslot0;
         w_rd1    = w_wslot1;
         w_rvalid = {w_wnum == 2'd2, w_wnum != 2'd0} & {2{!bus.flush_i}};
         w_pop    = 2'd0;
         w_store  = w_wnum - ((w_rreq < w_wnum) ? w_rreq : w_wnum);
         w_st0    = (w_wnum != w_store) ? w_wslot1 : w_wslot0;
      end
`endif
   end

   assign bus.read_valid_o = w_rvalid;
   assign bus.read_data_o  = {w_rd1, w_rd0};
   assign bus.count_o      = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (bus.flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + PW'(w_store);
         r_rptr  <= r_rptr + PW'(w_pop);
         r_count <= r_count + CW'(w_store) - CW'(w_pop);
      end
   end

   // NOTE: the data banks carry no reset; stale rows are never observed because valid comes from count.
   always_ff @(posedge clk) begin
      if ((!r_wptr[0] && w_store != 2'd0) || (r_wptr[0] && w_store == 2'd2))
         r_bank0[r_wptr[0] ? w_wrow_n : w_wrow] <= r_wptr[0] ? w_st1 : w_st0;
      if ((r_wptr[0] && w_store != 2'd0) || (!r_wptr[0] && w_store == 2'd2))
         r_bank1[w_wrow] <= r_wptr[0] ? w_st0 : w_st1;
   end
endmodule
